// File: rtl/glyph_pixel_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : glyph_pixel_reader_if
//  Brief    : Raster timing, text-buffer, glyph-memory and pixel-output bundle
//             for the glyph pixel reader. i_/o_ are from the reader's side.
//  Revision : 1.0  initial release
// ============================================================================
interface glyph_pixel_reader_if;
    logic        i_frame_start;
    logic        i_line_end;
    logic        i_pixel_en;
    logic [4:0]  o_cell_col;
    logic [4:0]  o_cell_row;
    logic [5:0]  i_char_code;
    logic [1:0]  o_glyph_x;
    logic [2:0]  o_glyph_y;
    logic [35:0] i_glyph_bits;
    logic        i_cursor_en;
    logic [4:0]  i_cursor_col;
    logic [4:0]  i_cursor_row;
    logic        o_pixel_on;
    logic        o_pixel_valid;

    modport slave (
        input  i_frame_start, i_line_end, i_pixel_en, i_char_code, i_glyph_bits,
               i_cursor_en, i_cursor_col, i_cursor_row,
        output o_cell_col, o_cell_row, o_glyph_x, o_glyph_y, o_pixel_on, o_pixel_valid
    );

    modport master (
        output i_frame_start, i_line_end, i_pixel_en, i_char_code, i_glyph_bits,
               i_cursor_en, i_cursor_col, i_cursor_row,
        input  o_cell_col, o_cell_row, o_glyph_x, o_glyph_y, o_pixel_on, o_pixel_valid
    );
endinterface
`default_nettype wire

// File: rtl/glyph_pixel_reader.sv
`default_nettype none
// ============================================================================
//  Module   : glyph_pixel_reader
//  Brief    : Walks the active raster, addresses text buffer and glyph memory,
//             and emits one monochrome pixel per strobe with a blinking cursor.
//  Revision : 1.0  initial release
// ============================================================================
module glyph_pixel_reader #(
    parameter int SCALE        = 4,
    parameter int COLS         = 32,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  wire logic            clk,
    input  wire logic            rst,
    glyph_pixel_reader_if.slave  io_rd
);

    localparam int c_SX_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int c_BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [c_SX_W-1:0] r_sx;
    logic [c_SX_W-1:0] r_sy;
    logic [2:0]        r_gx;
    logic [1:0]        r_gy;
    logic [4:0]        r_col;
    logic [4:0]        r_row;
    logic              r_in_x;
    logic              r_in_y;
    logic [c_BL_W-1:0] r_blink_cnt;
    logic              r_blink_ph;
    logic              r_s1_valid;
    logic              r_s1_dot;
    logic              r_s1_cur;
    logic              r_pixel_valid;
    logic              r_pixel_on;

    logic        w_sx_wrap;
    logic        w_gx_wrap;
    logic        w_col_last;
    logic        w_sy_wrap;
    logic        w_gy_wrap;
    logic        w_row_last;
    logic        w_blink_wrap;
    logic        w_dot;
    logic        w_cur;
    logic [63:0] w_bits_ext;
    logic        w_code_ok;
    logic        w_glyph_bit;

    assign w_sx_wrap    = (r_sx == c_SX_W'(SCALE - 1));
    assign w_gx_wrap    = w_sx_wrap && (r_gx == 3'd4);
    assign w_col_last   = (r_col == 5'(COLS - 1));
    assign w_sy_wrap    = (r_sy == c_SX_W'(SCALE - 1));
    assign w_gy_wrap    = w_sy_wrap && (r_gy == 2'd3);
    assign w_row_last   = (r_row == 5'(ROWS - 1));
    assign w_blink_wrap = (r_blink_cnt == c_BL_W'(BLINK_FRAMES - 1));

    // Gap dots (gx==4 / gy==3) are never foreground; the cursor still covers them.
    assign w_dot = r_in_x && r_in_y && (r_gx < 3'd4) && (r_gy < 2'd3);
    assign w_cur = io_rd.i_cursor_en && r_blink_ph && r_in_x && r_in_y &&
                   (r_col == io_rd.i_cursor_col) && (r_row == io_rd.i_cursor_row);

    // Zero-extend so codes 36..63 select a constant 0 without an out-of-range index.
    assign w_bits_ext  = {28'd0, io_rd.i_glyph_bits};
    assign w_code_ok   = (io_rd.i_char_code < 6'd36);
    assign w_glyph_bit = w_bits_ext[io_rd.i_char_code];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sx        <= '0;
            r_gx        <= '0;
            r_col       <= '0;
            r_in_x      <= 1'b1;
            r_sy        <= '0;
            r_gy        <= '0;
            r_row       <= '0;
            r_in_y      <= 1'b1;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (io_rd.i_frame_start) begin
            r_sx        <= '0;
            r_gx        <= '0;
            r_col       <= '0;
            r_in_x      <= 1'b1;
            r_sy        <= '0;
            r_gy        <= '0;
            r_row       <= '0;
            r_in_y      <= 1'b1;
            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
            if (w_blink_wrap) begin
                r_blink_ph <= ~r_blink_ph;
            end
        end else if (io_rd.i_line_end) begin
            r_sx   <= '0;
            r_gx   <= '0;
            r_col  <= '0;
            r_in_x <= 1'b1;
            if (r_in_y) begin
                r_sy <= w_sy_wrap ? '0 : r_sy + 1'b1;
                if (w_sy_wrap) begin
                    r_gy <= (r_gy == 2'd3) ? 2'd0 : r_gy + 2'd1;
                end
                if (w_gy_wrap) begin
                    if (w_row_last) begin
                        r_in_y <= 1'b0;
                    end else begin
                        r_row <= r_row + 5'd1;
                    end
                end
            end
        end else if (io_rd.i_pixel_en && r_in_x) begin
            r_sx <= w_sx_wrap ? '0 : r_sx + 1'b1;
            if (w_sx_wrap) begin
                r_gx <= (r_gx == 3'd4) ? 3'd0 : r_gx + 3'd1;
            end
            if (w_gx_wrap) begin
                if (w_col_last) begin
                    r_in_x <= 1'b0;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end
        end
    end

    // Two-stage pipeline lines up with the 1-cycle text buffer and glyph memory reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_dot      <= 1'b0;
            r_s1_cur      <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_pixel_on    <= 1'b0;
        end else begin
            r_s1_valid    <= io_rd.i_pixel_en;
            r_s1_dot      <= w_dot;
            r_s1_cur      <= w_cur;
            r_pixel_valid <= r_s1_valid;
            r_pixel_on    <= (r_s1_dot && w_code_ok && w_glyph_bit) ^ r_s1_cur;
        end
    end

    assign io_rd.o_cell_col    = r_col;
    assign io_rd.o_cell_row    = r_row;
    assign io_rd.o_glyph_x     = (r_gx < 3'd4) ? r_gx[1:0] : 2'd0;
    assign io_rd.o_glyph_y     = (r_gy < 2'd3) ? {1'b0, r_gy} : 3'd0;
    assign io_rd.o_pixel_on    = r_pixel_on;
    assign io_rd.o_pixel_valid = r_pixel_valid;

endmodule
`default_nettype wire

// File: tb/tb_glyph_pixel_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glyph_pixel_reader
//  Brief    : Randomized raster stimulus against a position/arithmetic model
//             of the glyph pixel reader, with text buffer and glyph memories.
//  Revision : 1.0  initial release
// ============================================================================
module tb_glyph_pixel_reader;

    localparam int SCALE = 4;
    localparam int COLS  = 32;
    localparam int ROWS  = 30;
    localparam int BLINK = 30;
    localparam int CW    = 5 * SCALE;
    localparam int CH    = 4 * SCALE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glyph_pixel_reader_if rd();

    glyph_pixel_reader #(
        .SCALE(SCALE), .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BLINK)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_rd (rd.slave)
    );

    logic [5:0] text [ROWS][COLS];
    bit         font [36][3][4];
    bit         all_ones;

    int  n_vec;
    int  n_err;
    int  p;        // pixel strobes since line start
    int  L;        // line_end pulses since frame start
    int  F;        // frame_start pulses since reset
    bit  hist1;
    bit  hist2;
    bit  expq[$];

    // Text buffer and glyph memory: registered reads of the DUT's addresses.
    always @(posedge clk) begin : mem_model
        logic [35:0] b;
        for (int i = 0; i < 36; i++) begin
            b[i] = all_ones ? 1'b1 :
                   (rd.o_glyph_y < 3) ? font[i][rd.o_glyph_y][rd.o_glyph_x] : 1'b0;
        end
        rd.i_glyph_bits <= b;
        rd.i_char_code  <= (rd.o_cell_row < ROWS) ? text[rd.o_cell_row][rd.o_cell_col] : 6'd0;
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t p=%0d L=%0d F=%0d)",
                     tag, obs, exp, $time, p, L, F);
        end
    endtask

    function automatic bit font_bit(input int code, input int y, input int x);
        if (code >= 36) return 1'b0;
        if (all_ones)   return 1'b1;
        return font[code][y][x];
    endfunction

    task automatic randomize_memories();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                text[r][c] = 6'($urandom_range(0, 63));
        for (int g = 0; g < 36; g++)
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++)
                    font[g][y][x] = bit'($urandom_range(0, 1));
    endtask

    // One clock cycle: drive, sample mid-cycle, predict, advance the model.
    task automatic step(input bit en, input bit le, input bit fs, input bit r);
        bit inx, iny, ph, cur, bitv;
        int col, row, gx, gy;
        rd.i_pixel_en    = en;
        rd.i_line_end    = le;
        rd.i_frame_start = fs;
        rst              = r;
        #3;
        check_value("pixel_valid", rd.o_pixel_valid, hist2);
        if (hist2) begin
            if (expq.size() == 0) check_value("exp_queue_empty", 1, 0);
            else                  check_value("pixel_on", rd.o_pixel_on, expq.pop_front());
        end
        inx = (p < COLS * CW);
        iny = (L < ROWS * CH);
        col = inx ? p / CW : COLS - 1;
        row = iny ? L / CH : ROWS - 1;
        gx  = (p / SCALE) % 5;
        gy  = (L / SCALE) % 4;
        if (en && !r) begin
            check_value("cell_col", rd.o_cell_col, col);
            check_value("cell_row", rd.o_cell_row, row);
            if (inx) check_value("glyph_x", rd.o_glyph_x, (gx < 4) ? gx : 0);
            if (iny) check_value("glyph_y", rd.o_glyph_y, (gy < 3) ? gy : 0);
            ph   = ((F / BLINK) % 2) == 1;
            cur  = rd.i_cursor_en && ph && inx && iny &&
                   (col == int'(rd.i_cursor_col)) && (row == int'(rd.i_cursor_row));
            bitv = (inx && iny && gx < 4 && gy < 3) ? font_bit(int'(text[row][col]), gy, gx) : 1'b0;
            expq.push_back(bitv ^ cur);
        end
        hist2 = hist1;
        hist1 = en && !r;
        if (r) begin
            hist1 = 0; hist2 = 0; expq.delete();
            p = 0; L = 0; F = 0;
        end else if (fs) begin
            p = 0; L = 0; F++;
        end else if (le) begin
            p = 0; L++;
        end else if (en) begin
            p++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            bit last;
            bit merge;
            last  = (i == npix - 1);
            merge = last && ($urandom_range(0, 1) == 1);
            if (gaps && $urandom_range(0, 3) == 0) step(0, 0, 0, 0);
            step(1, merge, 0, 0);
            if (last && !merge) step(0, 1, 0, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_vec = 0; n_err = 0;
        p = 0; L = 0; F = 0; hist1 = 0; hist2 = 0;
        all_ones = 0;
        rd.i_pixel_en = 0; rd.i_line_end = 0; rd.i_frame_start = 0;
        rd.i_cursor_en = 0; rd.i_cursor_col = 0; rd.i_cursor_row = 0;
        randomize_memories();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_pixel_on",    rd.o_pixel_on,    0);
        check_value("rst_pixel_valid", rd.o_pixel_valid, 0);
        check_value("rst_cell_col",    rd.o_cell_col,    0);
        check_value("rst_cell_row",    rd.o_cell_row,    0);
        check_value("rst_glyph_x",     rd.o_glyph_x,     0);
        check_value("rst_glyph_y",     rd.o_glyph_y,     0);

        // Random text over the first rows, full 700-pixel lines past the right edge.
        step(0, 0, 1, 0);
        for (int ln = 0; ln < 20; ln++) run_line(700, 1'b1);
        step(1, 0, 1, 0);
        for (int ln = 0; ln < 3; ln++) run_line(120, 1'b1);

        // Walk down to the bottom edge and past it.
        for (int i = 0; i < 472; i++) step(0, 1, 0, 0);
        for (int ln = 0; ln < 8; ln++) run_line(90, 1'b1);

        // Out-of-range codes with an all-ones glyph memory render blank.
        idle(3);
        all_ones = 1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                text[r][c] = 6'd40;
        step(0, 0, 1, 0);
        for (int ln = 0; ln < CH; ln++) run_line(2 * CW, 1'b0);
        idle(3);
        all_ones = 0;
        randomize_memories();

        // Cursor blink: fresh reset, then blink phase on after BLINK frames, off after 2*BLINK.
        step(0, 0, 0, 1);
        rd.i_cursor_en = 1; rd.i_cursor_col = 5'd0; rd.i_cursor_row = 5'd0;
        for (int i = 0; i < BLINK; i++) step(0, 0, 1, 0);
        for (int ln = 0; ln < CH + 2; ln++) run_line(2 * CW, 1'b1);
        rd.i_cursor_col = 5'd1;
        step(0, 0, 1, 0);
        for (int ln = 0; ln < 6; ln++) run_line(3 * CW, 1'b1);
        idle(2);
        for (int i = 0; i < BLINK - 1; i++) step(0, 0, 1, 0);
        for (int ln = 0; ln < CH; ln++) run_line(2 * CW, 1'b1);
        idle(2);
        rd.i_cursor_en = 0;

        // Reset in the middle of a pixel stream.
        step(0, 0, 1, 0);
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        run_line(100, 1'b1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
